key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two, 2..16).
REQ-002 SHALL have parameter LONG_CNT, default 50_000_000, long-press threshold in clk cycles (1 s at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; one clock domain only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_pulse  input  4  one-cycle debounced press pulses, bit k = key k.
REQ-006 SHALL have port key_in  input  4  raw key levels, active-low (0 = pressed).
REQ-007 SHALL have port ev_valid  output  1  head event available.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port ev_code  output  3  head event: [1:0] key index, [2] long-press flag.
REQ-010 SHALL have port ovf  output  1  sticky overflow/drop flag.
REQ-011 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-012 SHALL arbitrate key_pulse by fixed priority: lowest set index wins; all other set bits in that cycle are dropped and set ovf.
REQ-013 SHALL enqueue {0, idx} for the winning pulse in the same cycle the pulse is sampled; ev_valid rises the next cycle.
REQ-014 SHALL present the queue first-word-fall-through: ev_valid = not empty; ev_code = head entry, stable while ev_valid=1 and ev_ready=0.
REQ-015 SHALL pop the head on ev_valid=1 and ev_ready=1; ev_ready with ev_valid=0 has no effect.
REQ-016 SHALL, on push while full without a simultaneous pop, discard the new event, keep queue contents, and set ovf.
REQ-017 SHALL, on push and pop in the same cycle while full, accept both; count stays FIFO_DEPTH.
REQ-018 SHALL use pointers one bit wider than log2(FIFO_DEPTH) and wrap modulo 2*FIFO_DEPTH; full/empty derive from the MSB compare.
REQ-019 SHALL clear ovf when ovf_clr=1, except that a drop occurring in the same cycle leaves ovf=1 (set wins).
REQ-020 SHALL run a press tracker with states IDLE, TRACK, DONE.
REQ-021 SHALL, from any state, on an accepted press pulse for key k, go to TRACK, latch k, and clear the hold counter to 0.
REQ-022 SHALL, in TRACK, increment the hold counter each cycle while key_in[k]=0 and return to IDLE when key_in[k]=1.
REQ-023 SHALL, in TRACK, when the counter equals LONG_CNT-1 and key_in[k]=0, enqueue {1, k} and go to DONE; exactly one long event per press.
REQ-024 SHALL, in DONE, stay until key_in[k]=1, then go to IDLE.
REQ-025 SHALL, when a press pulse and the long-event condition occur in the same cycle, enqueue only the press; the long event is discarded and tracking restarts on the new key.

Reset
REQ-026 SHALL, on rst=1, immediately clear: queue pointers (empty), ev_valid=0, ev_code=3'b000, ovf=0, tracker=IDLE, hold counter=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all queued events and any in-progress long-press tracking.

Configuration
REQ-028 SHALL compile the tracker and long events only when LONG_PRESS_EN is defined.
REQ-029 SHALL, without LONG_PRESS_EN, omit tracker and counter, keep key_in as an unused port, and drive ev_code[2] as 0 for every event.

Structure
REQ-030 SHALL take KEY_NUM=4, the event code width (3), and the tracker state encoding from shared package key_evt_pkg.
REQ-031 SHALL implement the queue as sub-module key_evt_fifo (FWFT, parameterised depth, push/pop/full/empty ports).

Verification
REQ-032 SHALL verify: key_pulse=4'b0100 for 1 cycle, ev_ready=1 -> next cycle ev_valid=1, ev_code=3'b010; following cycle ev_valid=0.
REQ-033 SHALL verify: key_pulse=4'b1010 for 1 cycle -> exactly one event ev_code=3'b001; ovf=1.
REQ-034 SHALL verify: ev_ready=0, 5 pulses on keys 0,1,2,3,0 with FIFO_DEPTH=4 -> ovf=1; then drained in order 000,001,010,011; fifth event absent.
REQ-035 SHALL verify with LONG_PRESS_EN and LONG_CNT=100: key_in[3]=0 held for 150 cycles after pulse 4'b1000 -> events 011 then 111; no further event until release.
REQ-036 SHALL verify with LONG_PRESS_EN: key_in[1] released after 60 cycles (LONG_CNT=100) -> only event 001.
REQ-037 SHALL verify: rst=1 asserted with 3 events queued -> ev_valid=0 and ovf=0 in the same cycle; after release, queue stays empty.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared key-event definitions: key count, event code layout, press-tracker states
// and the fixed-priority arbitration helpers.
package key_evt_pkg;

   localparam int unsigned KEY_NUM = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned CODE_W  = 3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StTrack = 2'd1,
      StDone  = 2'd2
   } trk_state_e;

   // Lowest set index wins.
   function automatic logic [IDX_W-1:0] prio_idx(input logic [KEY_NUM-1:0] req);
      prio_idx = '0;
      for (int i = KEY_NUM - 1; i >= 0; i--) begin
         if (req[i]) prio_idx = IDX_W'(i);
      end
   endfunction

   function automatic logic multi_hot(input logic [KEY_NUM-1:0] req);
      multi_hot = |(req & (req - KEY_NUM'(1)));
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event queue with wrap-bit pointers; a push into a full
// queue is accepted only when a pop happens in the same cycle.
module key_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is forced to zero while empty so reset shows a clean code.
   assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: arbitrates press pulses into an event queue; define
// LONG_PRESS_EN to add the hold tracker that emits long-press events.
module key_event_ctrl
   import key_evt_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LONG_CNT   = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_NUM-1:0] key_pulse,
   input  logic [KEY_NUM-1:0] key_in,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [CODE_W-1:0]  ev_code,
   output logic               ovf,
   input  logic               ovf_clr
);

   logic              press, multi;
   logic [IDX_W-1:0]  press_idx;
   logic              long_ev;
   logic [CODE_W-1:0] long_code;
   logic              push, full, empty, drop;
   logic [CODE_W-1:0] wdata;
   logic              ovf_q, ovf_d;

   assign press     = |key_pulse;
   assign press_idx = prio_idx(key_pulse);
   assign multi     = multi_hot(key_pulse);

`ifdef LONG_PRESS_EN
   localparam int unsigned CNT_W = $clog2(LONG_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CNT - 1);

   trk_state_e       state_q, state_d;
   logic [IDX_W-1:0] key_q, key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      long_ev = 1'b0;
      // A new press always restarts tracking and suppresses a coincident long event.
      if (press) begin
         state_d = StTrack;
         key_d   = press_idx;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StTrack: begin
               if (key_in[key_q]) begin
                  state_d = StIdle;
               end else if (cnt_q == CNT_LAST) begin
                  long_ev = 1'b1;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StDone:  if (key_in[key_q]) state_d = StIdle;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         key_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
      end
   end

   assign long_code = {1'b1, key_q};
`else
   logic unused_key_in;
   assign unused_key_in = ^key_in;
   assign long_ev       = 1'b0;
   assign long_code     = '0;
`endif

   assign push  = press || long_ev;
   assign wdata = press ? {1'b0, press_idx} : long_code;

   key_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (ev_ready),
      .rdata (ev_code),
      .full  (full),
      .empty (empty)
   );

   assign ev_valid = !empty;
   // Full implies non-empty, so ev_ready alone decides whether the push fits.
   assign drop     = multi || (push && full && !ev_ready);

   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a scoreboard of expected event codes;
// long-press steps are included when LONG_PRESS_EN is defined.
module tb_key_event_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_pulse;
   logic [3:0] key_in;
   logic       ev_valid;
   logic       ev_ready;
   logic [2:0] ev_code;
   logic       ovf;
   logic       ovf_clr;

   logic [2:0] exp_q [$];
   int         n_tests = 0;
   int         n_fail  = 0;

   key_event_ctrl #(
      .FIFO_DEPTH (4),
      .LONG_CNT   (100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_pulse (key_pulse),
      .key_in    (key_in),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_code   (ev_code),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted transfer must match the oldest expected code.
   always @(negedge clk) begin
      logic [2:0] e;
      if (!rst && ev_valid && ev_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL unexpected_event obs=%b exp=none", ev_code);
         end else begin
            e = exp_q.pop_front();
            assert (ev_code === e) else begin
               n_fail++;
               $error("FAIL event_code obs=%b exp=%b", ev_code, e);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] p);
      key_pulse = p;
      step();
      key_pulse = 4'b0000;
   endtask

   initial begin
      rst       = 1'b1;
      key_pulse = 4'b0000;
      key_in    = 4'hF;
      ev_ready  = 1'b0;
      ovf_clr   = 1'b0;
      #1;
      chk("reset_valid", 32'(ev_valid), 32'd0);
      chk("reset_code", 32'(ev_code), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // Single press on key 2, visible one cycle later then popped.
      ev_ready = 1'b1;
      exp_q.push_back(3'b010);
      pulse(4'b0100);
      @(negedge clk);
      chk("k2_valid", 32'(ev_valid), 32'd1);
      step();
      @(negedge clk);
      chk("k2_gone", 32'(ev_valid), 32'd0);
      chk("k2_ovf", 32'(ovf), 32'd0);

      // Two simultaneous pulses: key 1 wins, key 3 is dropped.
      exp_q.push_back(3'b001);
      pulse(4'b1010);
      @(negedge clk);
      chk("multi_ovf", 32'(ovf), 32'd1);
      step();
      @(negedge clk);
      chk("multi_one_event", 32'(ev_valid), 32'd0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("ovf_cleared", 32'(ovf), 32'd0);

      // Overflow: five pulses into a depth-4 queue with no consumer.
      ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(3'(i));
         pulse(4'b0001 << (i % 4));
      end
      @(negedge clk);
      chk("full_ovf", 32'(ovf), 32'd1);
      chk("full_head", 32'(ev_code), 32'd0);
      step();
      step();
      @(negedge clk);
      chk("head_stable", 32'(ev_code), 32'd0);
      ev_ready = 1'b1;
      repeat (6) step();
      @(negedge clk);
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      chk("drain_empty", 32'(ev_valid), 32'd0);

      // A drop in the same cycle as ovf_clr keeps ovf set.
      ovf_clr = 1'b1;
      exp_q.push_back(3'b000);
      pulse(4'b0011);
      @(negedge clk);
      chk("set_wins", 32'(ovf), 32'd1);
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("clr_after", 32'(ovf), 32'd0);

      // Full queue with simultaneous push and pop accepts both.
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(3'(i));
         pulse(4'b0001 << i);
      end
      @(negedge clk);
      chk("full_no_ovf", 32'(ovf), 32'd0);
      step();
      ev_ready = 1'b1;
      exp_q.push_back(3'b010);
      pulse(4'b0100);
      @(negedge clk);
      chk("pushpop_ovf", 32'(ovf), 32'd0);
      repeat (6) step();
      @(negedge clk);
      chk("pushpop_pending", 32'(exp_q.size()), 32'd0);
      chk("pushpop_empty", 32'(ev_valid), 32'd0);

      // Reset with three events queued and ovf set.
      ev_ready = 1'b0;
      pulse(4'b0001);
      pulse(4'b0010);
      pulse(4'b0110);
      @(negedge clk);
      chk("pre_rst_ovf", 32'(ovf), 32'd1);
      chk("pre_rst_valid", 32'(ev_valid), 32'd1);
      step();
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(ev_valid), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_code", 32'(ev_code), 32'd0);
      exp_q.delete();
      step();
      rst = 1'b0;
      ev_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("post_rst_empty", 32'(ev_valid), 32'd0);

`ifdef LONG_PRESS_EN
      // Key 3 held for 150 cycles: press event, then one long event at count 100.
      exp_q.push_back(3'b011);
      exp_q.push_back(3'b111);
      key_in = 4'b0111;
      pulse(4'b1000);
      repeat (99) step();
      @(negedge clk);
      chk("long_not_yet", 32'(ev_valid), 32'd0);
      step();
      @(negedge clk);
      chk("long_fires", 32'(ev_valid), 32'd1);
      repeat (49) step();
      key_in = 4'hF;
      repeat (5) step();
      @(negedge clk);
      chk("long_pending", 32'(exp_q.size()), 32'd0);
      chk("long_idle", 32'(ev_valid), 32'd0);

      // Key 1 released after 60 cycles: press event only.
      exp_q.push_back(3'b001);
      key_in = 4'b1101;
      pulse(4'b0010);
      repeat (59) step();
      key_in = 4'hF;
      repeat (120) step();
      @(negedge clk);
      chk("short_pending", 32'(exp_q.size()), 32'd0);
      chk("short_idle", 32'(ev_valid), 32'd0);
`endif

      step();
      chk("final_pending", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
